// File: rtl/mole_pkg.sv
// Shared constants, FSM encoding and saturating-add helpers
// for the mole hit detector.
package mole_pkg;

  localparam int N_HOLES  = 8;
  localparam int SCORE_W  = 8;
  localparam int STREAK_W = 6;

  localparam int unsigned SCORE_MAX  = (1 << SCORE_W) - 1;
  localparam int unsigned STREAK_MAX = (1 << STREAK_W) - 1;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    IDLE  = 2'd1,
    PLAY  = 2'd2
  } state_t;

  function automatic logic [SCORE_W-1:0] score_add(
    input logic [SCORE_W-1:0] a,
    input int unsigned        b
  );
    int unsigned s;
    s = 32'(a) + b;
    if (s > SCORE_MAX) return '1;
    return s[SCORE_W-1:0];
  endfunction

  function automatic logic [STREAK_W-1:0] streak_add(
    input logic [STREAK_W-1:0] a,
    input int unsigned         b
  );
    int unsigned s;
    s = 32'(a) + b;
    if (s > STREAK_MAX) return '1;
    return s[STREAK_W-1:0];
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// One switch: 2-flop synchronizer, stability counter, debounced level, strike pulse.
// Ports: clk, rst (sync, high), prime (track level, no strikes), sw (raw), strike (1-cycle).
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic prime,
  input  logic sw,
  output logic strike
);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      strike <= 1'b0;
    end else begin
      sync1  <= sw;
      sync2  <= sync1;
      strike <= 1'b0;
      if (prime) begin
        stable <= sync2;
        cnt    <= '0;
      end else if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // new level accepted; either edge direction is a strike
        stable <= sync2;
        cnt    <= '0;
        strike <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mole_hit_detector.sv
// Debounces player switches, qualifies strikes against lit moles, counts hits/misses.
// Ports: CLK100MHZ, RST_BTN (sync, high), switches, game_active, mole, enable ->
//   hit_pulse, miss_pulse, hit_mask, hits_total, misses_total, streak.
// Optional: define HIT_DETECT_STREAK_EN for the streak counter (else streak = 0).
module mole_hit_detector
  import mole_pkg::*;
#(
  parameter int N_HOLES         = mole_pkg::N_HOLES,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                CLK100MHZ,
  input  logic                RST_BTN,
  input  logic [N_HOLES-1:0]  switches,
  input  logic                game_active,
  input  logic [N_HOLES-1:0]  mole,
  input  logic                enable,
  output logic [N_HOLES-1:0]  hit_pulse,
  output logic                miss_pulse,
  output logic [N_HOLES-1:0]  hit_mask,
  output logic [SCORE_W-1:0]  hits_total,
  output logic [SCORE_W-1:0]  misses_total,
  output logic [STREAK_W-1:0] streak
);

  state_t             state;
  state_t             state_n;
  logic [CNT_W:0]     prime_cnt;
  logic               game_q;
  logic               prime;
  logic               clear;
  logic               qualify;
  logic [N_HOLES-1:0] strike;
  logic [N_HOLES-1:0] eff_mask;
  logic [N_HOLES-1:0] hits;
  logic [N_HOLES-1:0] miss_vec;
  logic               any_miss;
  int unsigned        hit_cnt;

  for (genvar i = 0; i < N_HOLES; i++) begin : g_deb
    switch_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk   (CLK100MHZ),
      .rst   (RST_BTN),
      .prime (prime),
      .sw    (switches[i]),
      .strike(strike[i])
    );
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST_BTN) begin
      state     <= PRIME;
      prime_cnt <= '0;
      game_q    <= 1'b0;
    end else begin
      state     <= state_n;
      game_q    <= game_active;
      prime_cnt <= (state == PRIME) ?
                   prime_cnt + (CNT_W+1)'(1) : '0;
    end
  end

  always_comb begin
    state_n = state;
    prime   = 1'b0;
    clear   = 1'b0;
    qualify = 1'b0;
    unique case (state)
      PRIME: begin
        prime = 1'b1;
        if (prime_cnt == (CNT_W+1)'(DEBOUNCE_CYCLES + 1))
          state_n = IDLE;
      end
      IDLE: begin
        if (game_active && !game_q) begin
          state_n = PLAY;
          clear   = 1'b1;
        end
      end
      PLAY: begin
        if (!game_active) state_n = IDLE;
        else              qualify = 1'b1;
      end
      default: state_n = PRIME;
    endcase
  end

  // enable opens a fresh period: old mask does not block this cycle's strikes
  always_comb begin
    eff_mask = enable ? '0 : hit_mask;
    hits     = strike & mole & ~eff_mask;
    miss_vec = strike & ~mole & ~eff_mask;
    any_miss = |miss_vec;
    hit_cnt  = 0;
    for (int i = 0; i < N_HOLES; i++)
      hit_cnt += 32'(hits[i]);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST_BTN || clear) begin
      hit_pulse    <= '0;
      miss_pulse   <= 1'b0;
      hit_mask     <= '0;
      hits_total   <= '0;
      misses_total <= '0;
    end else if (qualify) begin
      hit_pulse    <= hits;
      miss_pulse   <= any_miss;
      hit_mask     <= enable ? hits : (hit_mask | hits);
      hits_total   <= score_add(hits_total, hit_cnt);
      misses_total <= score_add(misses_total,
                                any_miss ? 1 : 0);
    end else begin
      hit_pulse  <= '0;
      miss_pulse <= 1'b0;
    end
  end

`ifdef HIT_DETECT_STREAK_EN
  logic [STREAK_W-1:0] streak_q;

  // a miss wins over hits landing in the same cycle
  always_ff @(posedge CLK100MHZ) begin
    if (RST_BTN || clear)
      streak_q <= '0;
    else if (qualify)
      streak_q <= any_miss ? '0 :
                  streak_add(streak_q, hit_cnt);
  end

  assign streak = streak_q;
`else
  assign streak = '0;
`endif

endmodule

// File: tb/tb_mole_hit_detector.sv
// Directed + randomized bench for mole_hit_detector (DEBOUNCE_CYCLES=4),
// with a per-strike reference model of hits, misses, mask and streak.
module tb_mole_hit_detector;
  import mole_pkg::*;

  localparam int D   = 4;
  localparam int LAT = 2 + D + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       ga;
  logic [7:0] mole;
  logic       en;
  logic [7:0] hit_pulse;
  logic       miss_pulse;
  logic [7:0] hit_mask;
  logic [7:0] hits_total;
  logic [7:0] misses_total;
  logic [5:0] streak;

  int total = 0;
  int bad   = 0;

  int         m_hits   = 0;
  int         m_misses = 0;
  int         m_streak = 0;
  logic [7:0] m_mask   = '0;

  always #5 clk = ~clk;

  mole_hit_detector #(
    .N_HOLES        (8),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (20)
  ) dut (
    .CLK100MHZ   (clk),
    .RST_BTN     (rst),
    .switches    (sw),
    .game_active (ga),
    .mole        (mole),
    .enable      (en),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .hit_mask    (hit_mask),
    .hits_total  (hits_total),
    .misses_total(misses_total),
    .streak      (streak)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int exp_streak();
`ifdef HIT_DETECT_STREAK_EN
    return m_streak;
`else
    return 0;
`endif
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_hits"},   32'(hits_total),   m_hits);
    chk({tag, "_misses"}, 32'(misses_total), m_misses);
    chk({tag, "_mask"},   32'(hit_mask),     32'(m_mask));
    chk({tag, "_streak"}, 32'(streak),       exp_streak());
  endtask

  // one toggle event: each hole judged on its own
  task automatic model_strike(input  logic [7:0] s,
                              input  logic [7:0] m,
                              input  logic       e,
                              output logic [7:0] eh,
                              output logic       em);
    int n;
    eh = '0;
    em = 1'b0;
    n  = 0;
    if (e) m_mask = '0;
    for (int i = 0; i < 8; i++) begin
      if (s[i] && !m_mask[i]) begin
        if (m[i]) begin
          eh[i] = 1'b1;
          n++;
        end else begin
          em = 1'b1;
        end
      end
    end
    m_mask   = e ? eh : (m_mask | eh);
    m_hits   = (m_hits + n > 255) ? 255 : m_hits + n;
    if (em) m_misses = (m_misses == 255) ? 255 : m_misses + 1;
    if (em)              m_streak = 0;
    else if (m_streak + n > 63) m_streak = 63;
    else                 m_streak = m_streak + n;
  endtask

  // toggle switches s, optionally enable in the qualifying cycle
  task automatic strike(input string tag,
                        input logic [7:0] s,
                        input logic [7:0] m,
                        input logic       e);
    logic [7:0] eh;
    logic       em;
    mole = m;
    model_strike(s, m, e, eh, em);
    sw = sw ^ s;
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k < LAT)
        chk({tag, "_early"}, {23'b0, hit_pulse, miss_pulse}, 0);
      if (k == LAT - 1 && e) en = 1'b1;
    end
    en = 1'b0;
    chk({tag, "_hit_pulse"},  32'(hit_pulse),  32'(eh));
    chk({tag, "_miss_pulse"}, 32'(miss_pulse), 32'(em));
    step();
    chk({tag, "_pulse_end"}, {23'b0, hit_pulse, miss_pulse}, 0);
    check_state(tag);
  endtask

  task automatic quiet(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      chk({tag, "_quiet"}, {23'b0, hit_pulse, miss_pulse}, 0);
    end
  endtask

  initial begin
    rst  = 1'b1;
    sw   = 8'h08;
    ga   = 1'b0;
    mole = '0;
    en   = 1'b0;
    step();
    step();
    step();
    chk("rst_hit_pulse", 32'(hit_pulse), 0);
    chk("rst_miss_pulse", 32'(miss_pulse), 0);
    check_state("rst");
    rst = 1'b0;
    quiet("prime", 10);
    ga = 1'b1;
    quiet("start", 10);
    check_state("start");

    strike("hit_sw2", 8'h04, 8'h04, 1'b0);
    strike("repeat_sw2", 8'h04, 8'h04, 1'b0);
    en = 1'b1;
    step();
    en = 1'b0;
    m_mask = '0;
    step();
    check_state("period");
    strike("rehit_sw2", 8'h04, 8'h04, 1'b0);
    chk("rehit_total", 32'(hits_total), 2);
    strike("miss_56", 8'h60, 8'h01, 1'b0);
    chk("miss_total", 32'(misses_total), 1);

    sw[0] = 1'b1;
    step();
    step();
    step();
    sw[0] = 1'b0;
    quiet("glitch", 12);
    check_state("glitch");

    strike("pre_sw2", 8'h04, 8'h04, 1'b1);
    strike("en_sw1", 8'h02, 8'h02, 1'b1);
    chk("en_sw1_mask", 32'(hit_mask), 32'h02);

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 4) == 0) begin
        en = 1'b1;
        step();
        en = 1'b0;
        m_mask = '0;
        step();
      end
      strike("rand", 8'($urandom_range(1, 255)),
             8'($urandom), ($urandom_range(0, 3) == 0));
    end

    ga = 1'b0;
    step();
    step();
    sw = sw ^ 8'h0f;
    quiet("idle", LAT + 3);
    check_state("idle");
    ga = 1'b1;
    step();
    step();
    m_hits   = 0;
    m_misses = 0;
    m_streak = 0;
    m_mask   = '0;
    check_state("restart");

    for (int r = 0; r < 40; r++)
      strike("sat", 8'hff, 8'hff, 1'b1);
    chk("sat_hits", 32'(hits_total), 255);

    rst = 1'b1;
    step();
    chk("midrst_hit_pulse", 32'(hit_pulse), 0);
    chk("midrst_miss_pulse", 32'(miss_pulse), 0);
    chk("midrst_mask", 32'(hit_mask), 0);
    chk("midrst_hits", 32'(hits_total), 0);
    chk("midrst_misses", 32'(misses_total), 0);
    chk("midrst_streak", 32'(streak), 0);
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
